field_edit_scheduler: RTL and testbench
=======================================

FIELD_EDIT_SCHEDULER -- requirements
Module: field_edit_scheduler

Interface
REQ-001 Parameter HOLD_CYC, default 50000000: cycles a direction button must stay held after its first step before auto-repeat starts.
REQ-002 Parameter REP_CYC, default 25000000: cycles between auto-repeat steps.
REQ-003 Parameter N_FIELDS, default 7: number of editable fields, codes 1..N_FIELDS; code 7 = day-of-week counter.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 edit_sw  input  1  level; 1 = edit mode requested.
REQ-007 btn_next, btn_prev  input  1 each  debounced synchronous levels; select next/previous field.
REQ-008 btn_up, btn_down  input  1 each  debounced synchronous levels; increment/decrement the selected field.
REQ-009 wr_ack  input  1  one-cycle acknowledge from the RTC write sequencer.
REQ-010 en_count  output  4  selected field code; 0 = no field selected.
REQ-011 enUP, enDOWN  output  1 each  one-cycle step pulses to the field counters.
REQ-012 wr_req  output  1  commit request to the RTC write sequencer.
REQ-013 editing  output  1  high only in state EDIT.

Function
REQ-014 Main FSM states SHALL be IDLE, EDIT and COMMIT, with registered outputs.
REQ-015 IDLE: en_count=0, enUP=enDOWN=wr_req=0; edit_sw=1 sampled -> EDIT next cycle with en_count=1.
REQ-016 EDIT: a rising edge of btn_next SHALL increment en_count, wrapping N_FIELDS->1; a rising edge of btn_prev SHALL decrement it, wrapping 1->N_FIELDS.
REQ-017 Simultaneous btn_next and btn_prev edges in the same cycle SHALL leave en_count unchanged.
REQ-018 Rising edge of btn_up sampled at cycle k (low at k-1, high at k) SHALL assert enUP during cycle k+1 only; btn_down/enDOWN SHALL behave identically.
REQ-019 While the button stays held, a second pulse SHALL occur HOLD_CYC cycles after the first, then one pulse every REP_CYC cycles.
REQ-020 Releasing the button SHALL stop pulses from the next cycle and clear the repeat timer.
REQ-021 btn_up and btn_down both high SHALL produce no pulses and clear the repeat timer; pulses resume only after both are released and one is pressed again.
REQ-022 A field change (REQ-016) SHALL clear the repeat timer and suppress pulses until the direction button is released.
REQ-023 enUP and enDOWN SHALL never be high together, and SHALL never be high outside EDIT.
REQ-024 edit_sw=0 sampled in EDIT -> COMMIT; entering COMMIT SHALL set en_count=0 and assert wr_req.
REQ-025 wr_req SHALL stay high until wr_ack is sampled high, then the FSM SHALL go to IDLE with wr_req=0 on the following cycle.
REQ-026 wr_ack outside COMMIT SHALL be ignored; edit_sw during COMMIT SHALL be ignored, and IDLE re-enters EDIT per REQ-015 if edit_sw is still high.
REQ-027 Repeat timer width SHALL be ceil(log2(max(HOLD_CYC,REP_CYC)+1)) bits; no overflow is permitted.

Reset
REQ-028 reset SHALL force, asynchronously: state IDLE, en_count=0, enUP=enDOWN=wr_req=editing=0, repeat timer 0, and all edge-detect registers 0.
REQ-029 Reset during COMMIT SHALL drop wr_req immediately; the write is abandoned.
REQ-030 A button held through reset release SHALL count as a rising edge on the first post-reset cycle; it takes effect only in EDIT.

Structure
REQ-031 Field code constants (FLD_SEC=1 .. FLD_DOW=7) and the FSM state encodings SHALL live in the shared rtc_edit_pkg include.
REQ-032 Edge detection plus hold/repeat timing SHALL be one sub-module, key_repeat, instantiated once per direction button; the up/down conflict rule is applied in the top level.

Verification (HOLD_CYC=10, REP_CYC=4)
REQ-033 edit_sw=1 from IDLE, then 8 btn_next presses -> en_count 1,2,..,7,1,2; editing=1 throughout.
REQ-034 In EDIT with en_count=7, hold btn_up for 30 cycles -> enUP pulses at k+1, k+11, k+15, k+19, k+23, k+27; enDOWN stays 0.
REQ-035 Hold btn_up and raise btn_down mid-repeat -> no further pulses; release both, press btn_down -> a single enDOWN pulse.
REQ-036 btn_prev at en_count=1 -> 7; btn_next and btn_prev edges in the same cycle -> no change.
REQ-037 edit_sw=0 -> wr_req=1 and en_count=0; hold wr_ack low for 5 cycles, then pulse it -> wr_req falls the next cycle, state IDLE.
REQ-038 Assert reset during COMMIT and during a repeat -> all outputs 0 immediately; no pulses after release until EDIT is re-entered.

Source files
------------

// File: rtl/field_edit_scheduler_pkg.sv
//==============================================================================
// rtc_edit_pkg -- field codes, FSM encodings and timer sizing shared by the
// RTC edit-mode scheduler.                                          Rev 1.0
//==============================================================================
`default_nettype none

package rtc_edit_pkg;

  localparam logic [3:0] FLD_NONE  = 4'd0;
  localparam logic [3:0] FLD_SEC   = 4'd1;
  localparam logic [3:0] FLD_MIN   = 4'd2;
  localparam logic [3:0] FLD_HOUR  = 4'd3;
  localparam logic [3:0] FLD_DATE  = 4'd4;
  localparam logic [3:0] FLD_MONTH = 4'd5;
  localparam logic [3:0] FLD_YEAR  = 4'd6;
  localparam logic [3:0] FLD_DOW   = 4'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Wide enough to hold the larger of the two intervals without wrapping.
  function automatic int tmr_width(input int hold_cyc, input int rep_cyc);
    int m;
    m = (hold_cyc > rep_cyc) ? hold_cyc : rep_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/field_edit_scheduler_key_repeat.sv
//==============================================================================
// key_repeat -- rising-edge step plus hold-then-repeat stepping for one
// direction button.                                                 Rev 1.0
//==============================================================================
`default_nettype none

module key_repeat
  import rtc_edit_pkg::*;
#(
  parameter int HOLD_CYC = 50000000,
  parameter int REP_CYC  = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic kill_i,
  output logic step_o
);

  localparam int TW = tmr_width(HOLD_CYC, REP_CYC);

  logic          btn_q;
  logic          armed_q, armed_d;
  logic          rep_q, rep_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] w_lim;

  assign w_lim = rep_q ? TW'(REP_CYC) : TW'(HOLD_CYC);

  // A kill disarms until release: with btn_q still high no fresh edge can re-arm.
  always_comb begin
    step_o  = 1'b0;
    armed_d = armed_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    if (kill_i || !btn_i) begin
      armed_d = 1'b0;
      rep_d   = 1'b0;
      cnt_d   = '0;
    end else if (!btn_q) begin
      step_o  = 1'b1;
      armed_d = 1'b1;
      rep_d   = 1'b0;
      cnt_d   = TW'(1);
    end else if (armed_q) begin
      if (cnt_q == w_lim) begin
        step_o = 1'b1;
        rep_d  = 1'b1;
        cnt_d  = TW'(1);
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      btn_q   <= btn_i;
      armed_q <= armed_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/field_edit_scheduler.sv
//==============================================================================
// field_edit_scheduler -- RTC edit mode: field selection, up/down step pulses
// with auto-repeat, and commit handshake to the write sequencer.   Rev 1.0
//==============================================================================
`default_nettype none

module field_edit_scheduler
  import rtc_edit_pkg::*;
#(
  parameter int HOLD_CYC = 50000000,
  parameter int REP_CYC  = 25000000,
  parameter int N_FIELDS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_sw,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       wr_ack,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       wr_req,
  output logic       editing
);

  logic [1:0] state_q, state_d;
  logic [3:0] en_count_q, en_count_d;
  logic       enup_q, enup_d;
  logic       endn_q, endn_d;
  logic       wr_req_q, wr_req_d;
  logic       editing_q;
  logic       next_q, prev_q;

  logic w_act, w_next_e, w_prev_e, w_fld_chg, w_kill;
  logic w_step_up, w_step_dn;

  // Stepping only while EDIT persists into the next cycle, so no pulse leaks into COMMIT.
  assign w_act     = (state_q == ST_EDIT) && edit_sw;
  assign w_next_e  = btn_next && !next_q;
  assign w_prev_e  = btn_prev && !prev_q;
  assign w_fld_chg = w_act && (w_next_e ^ w_prev_e);
  assign w_kill    = !w_act || w_fld_chg || (btn_up && btn_down);

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .kill_i(w_kill), .step_o(w_step_up)
  );

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_dn (
    .clk(clk), .reset(reset), .btn_i(btn_down), .kill_i(w_kill), .step_o(w_step_dn)
  );

  always_comb begin
    state_d    = state_q;
    en_count_d = en_count_q;
    wr_req_d   = wr_req_q;
    enup_d     = 1'b0;
    endn_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        en_count_d = FLD_NONE;
        wr_req_d   = 1'b0;
        if (edit_sw) begin
          state_d    = ST_EDIT;
          en_count_d = FLD_SEC;
        end
      end
      ST_EDIT: begin
        if (!edit_sw) begin
          state_d    = ST_COMMIT;
          en_count_d = FLD_NONE;
          wr_req_d   = 1'b1;
        end else begin
          if (w_fld_chg) begin
            if (w_next_e)
              en_count_d = (en_count_q >= 4'(N_FIELDS)) ? FLD_SEC : en_count_q + 4'd1;
            else
              en_count_d = (en_count_q <= FLD_SEC) ? 4'(N_FIELDS) : en_count_q - 4'd1;
          end
          enup_d = w_step_up;
          endn_d = w_step_dn;
        end
      end
      ST_COMMIT: begin
        if (wr_ack) begin
          state_d  = ST_IDLE;
          wr_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        en_count_d = FLD_NONE;
        wr_req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_count_q <= FLD_NONE;
      enup_q     <= 1'b0;
      endn_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      editing_q  <= 1'b0;
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_count_q <= en_count_d;
      enup_q     <= enup_d;
      endn_q     <= endn_d;
      wr_req_q   <= wr_req_d;
      editing_q  <= (state_d == ST_EDIT);
      next_q     <= btn_next;
      prev_q     <= btn_prev;
    end
  end

  assign en_count = en_count_q;
  assign enUP     = enup_q;
  assign enDOWN   = endn_q;
  assign wr_req   = wr_req_q;
  assign editing  = editing_q;

endmodule

`default_nettype wire

// File: tb/tb_field_edit_scheduler.sv
//==============================================================================
// tb_field_edit_scheduler -- directed stimulus with an expected-event
// scoreboard for field_edit_scheduler (HOLD_CYC=10, REP_CYC=4).    Rev 1.0
//==============================================================================
`default_nettype none

module tb_field_edit_scheduler;

  logic       clk, reset, edit_sw, btn_next, btn_prev, btn_up, btn_down, wr_ack;
  logic [3:0] en_count;
  logic       enUP, enDOWN, wr_req, editing;

  field_edit_scheduler #(.HOLD_CYC(10), .REP_CYC(4), .N_FIELDS(7)) dut (
    .clk(clk), .reset(reset), .edit_sw(edit_sw),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_up(btn_up), .btn_down(btn_down),
    .wr_ack(wr_ack), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .wr_req(wr_req), .editing(editing)
  );

  typedef struct {
    byte k;
    int  v;
    int  c;
  } ev_t;

  ev_t exq[$];
  int  cyc;
  int  n_cmp;
  int  n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expected events kept sorted by cycle; same-cycle order is C, E, W, U, D.
  task automatic push(input byte k, input int v, input int off);
    ev_t e;
    int  i;
    e.k = k;
    e.v = v;
    e.c = cyc + off;
    i = exq.size();
    while (i > 0 && exq[i-1].c > e.c) i--;
    exq.insert(i, e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic ev(input byte k, input int v);
    ev_t e;
    n_cmp++;
    if (exq.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %c=%0d @cyc %0d, required none", k, v, cyc);
    end else begin
      e = exq.pop_front();
      if (e.k != k || e.v != v || e.c != cyc) begin
        n_bad++;
        $display("FAIL event: got %c=%0d @cyc %0d, required %c=%0d @cyc %0d",
                 k, v, cyc, e.k, e.v, e.c);
      end
    end
  endtask

  // Monitor: every output change or step pulse is an event to be matched.
  logic [3:0] p_cnt;
  logic       p_ed, p_wr;
  initial begin
    p_cnt = 4'd0;
    p_ed  = 1'b0;
    p_wr  = 1'b0;
    forever begin
      @(negedge clk);
      if (en_count !== p_cnt) ev("C", int'(en_count));
      p_cnt = en_count;
      if (editing !== p_ed) ev("E", int'(editing));
      p_ed = editing;
      if (wr_req !== p_wr) ev("W", int'(wr_req));
      p_wr = wr_req;
      if (enUP !== 1'b0) ev("U", int'(enUP));
      if (enDOWN !== 1'b0) ev("D", int'(enDOWN));
    end
  end

  int nxt_tab[8] = '{2, 3, 4, 5, 6, 7, 1, 2};
  int prv_tab[2] = '{1, 7};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; edit_sw = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; wr_ack = 1'b0;
    #1;
    chk("rst_en_count", int'(en_count), 0);
    chk("rst_enUP", int'(enUP), 0);
    chk("rst_enDOWN", int'(enDOWN), 0);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_editing", int'(editing), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // enter EDIT, walk fields forward with wrap
    edit_sw = 1'b1; push("C", 1, 1); push("E", 1, 1);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      btn_next = 1'b1; push("C", nxt_tab[i], 1);
      tick(1);
      btn_next = 1'b0;
      tick(1);
    end
    for (int i = 0; i < 2; i++) begin
      btn_prev = 1'b1; push("C", prv_tab[i], 1);
      tick(1);
      btn_prev = 1'b0;
      tick(1);
    end

    // hold up: first step, hold delay, then repeat
    btn_up = 1'b1;
    push("U", 1, 1);  push("U", 1, 11); push("U", 1, 15);
    push("U", 1, 19); push("U", 1, 23); push("U", 1, 27);
    tick(30);
    btn_up = 1'b0;
    tick(3);

    // up/down conflict mid-repeat, then a lone down press
    btn_up = 1'b1;
    push("U", 1, 1); push("U", 1, 11); push("U", 1, 15);
    tick(16);
    btn_down = 1'b1;
    tick(6);
    btn_down = 1'b0;
    tick(12);
    btn_up = 1'b0;
    tick(2);
    btn_down = 1'b1; push("D", 1, 1);
    tick(3);
    btn_down = 1'b0;
    tick(2);

    // field change while up is held suppresses repeat
    btn_up = 1'b1; push("U", 1, 1);
    tick(4);
    btn_next = 1'b1; push("C", 1, 1);
    tick(1);
    btn_next = 1'b0;
    tick(15);
    btn_up = 1'b0;
    tick(2);

    // prev wrap, then simultaneous next/prev edges
    btn_prev = 1'b1; push("C", 7, 1);
    tick(1);
    btn_prev = 1'b0;
    tick(1);
    btn_next = 1'b1; btn_prev = 1'b1;
    tick(1);
    btn_next = 1'b0; btn_prev = 1'b0;
    tick(2);
    btn_next = 1'b1; push("C", 1, 1);
    tick(1);
    btn_next = 1'b0;
    tick(1);

    // commit handshake
    edit_sw = 1'b0; push("C", 0, 1); push("E", 0, 1); push("W", 1, 1);
    tick(5);
    wr_ack = 1'b1; push("W", 0, 1);
    tick(1);
    wr_ack = 1'b0;
    tick(3);

    // stray ack in IDLE; edit_sw raised during COMMIT re-enters EDIT after ack
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    tick(1);
    edit_sw = 1'b1; push("C", 1, 1); push("E", 1, 1);
    tick(3);
    edit_sw = 1'b0; push("C", 0, 1); push("E", 0, 1); push("W", 1, 1);
    tick(2);
    edit_sw = 1'b1;
    tick(2);
    wr_ack = 1'b1; push("W", 0, 1); push("C", 1, 2); push("E", 1, 2);
    tick(1);
    wr_ack = 1'b0;
    tick(2);

    // reset during repeat; button held through release must not step
    btn_up = 1'b1; push("U", 1, 1); push("U", 1, 11);
    tick(13);
    #1;
    reset = 1'b1; push("C", 0, 0); push("E", 0, 0);
    #1;
    chk("rep_rst_en_count", int'(en_count), 0);
    chk("rep_rst_enUP", int'(enUP), 0);
    chk("rep_rst_editing", int'(editing), 0);
    edit_sw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);
    edit_sw = 1'b1; push("C", 1, 1); push("E", 1, 1);
    tick(12);
    btn_up = 1'b0;
    tick(2);
    btn_up = 1'b1; push("U", 1, 1);
    tick(2);
    btn_up = 1'b0;
    tick(2);

    // reset during COMMIT abandons the write
    edit_sw = 1'b0; push("C", 0, 1); push("E", 0, 1); push("W", 1, 1);
    tick(3);
    #1;
    reset = 1'b1; push("W", 0, 0);
    #1;
    chk("commit_rst_wr_req", int'(wr_req), 0);
    chk("commit_rst_en_count", int'(en_count), 0);
    chk("commit_rst_editing", int'(editing), 0);
    tick(2);
    reset = 1'b0;
    tick(6);

    chk("pending_events", exq.size(), 0);
    while (exq.size() > 0) begin
      ev_t e;
      e = exq.pop_front();
      $display("FAIL missing: got nothing, required %c=%0d @cyc %0d", e.k, e.v, e.c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
